// File: rtl/pll_reset_sequencer_if.sv
// Purpose: groups the PLL sequencer's lock/restart inputs and status outputs.
// Latency: none, wires only.
// Backpressure: none; every signal is a plain level or a single-cycle pulse.
interface pll_reset_sequencer_if;
    logic       in_pll_lock;
    logic       in_restart;
    logic       out_pll_reset;
    logic       out_sys_rst_n;
    logic       out_ready;
    logic       out_fault;
    logic [3:0] out_retry_count;
    logic [2:0] out_state;

    // Sequencer side: watches lock and restart, drives reset and status.
    modport master (
        input  in_pll_lock,
        input  in_restart,
        output out_pll_reset,
        output out_sys_rst_n,
        output out_ready,
        output out_fault,
        output out_retry_count,
        output out_state
    );

    // PLL and system side: drives lock and restart, observes the sequencer.
    modport slave (
        output in_pll_lock,
        output in_restart,
        input  out_pll_reset,
        input  out_sys_rst_n,
        input  out_ready,
        input  out_fault,
        input  out_retry_count,
        input  out_state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Purpose: pulses the rPLL reset, waits for stable lock, then releases sys reset; retries on timeout, faults after that.
// Latency: lock rise to release is 3 + LOCK_STABLE_CYCLES edges; lock loss to reset is 3 edges.
// Backpressure: none; in_restart is accepted on any cycle and overrides every other transition.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  in_clk_27mhz,
    input  logic                  in_rst_n,
    pll_reset_sequencer_if.master bus
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_C = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;

    // Terminal counts: each phase lasts exactly its parameter in cycles,
    // so the transition happens when the counter holds the last index.
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    retry, retry_nx;
    logic          lock_meta, lock_s;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge in_clk_27mhz or negedge in_rst_n) begin
        if (!in_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.in_pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State, phase counter and retry count registers.
    always_ff @(posedge in_clk_27mhz or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= RESET_PLL;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            retry <= retry_nx;
        end
    end

    // Next-state logic; restart wins over everything, lock wins over timeout.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        retry_nx = retry;
        if (bus.in_restart) begin
            state_nx = RESET_PLL;
            cnt_nx   = '0;
            retry_nx = '0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_nx = WAIT_LOCK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = STABLE;
                        cnt_nx   = '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt_nx = '0;
                        if (retry < MAX_R) begin
                            retry_nx = retry + 4'd1;
                            state_nx = RESET_PLL;
                        end else begin
                            state_nx = FAULT;
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        // A dropout is not a timeout: back to waiting with a fresh window.
                        state_nx = WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        // Losing lock after release starts a brand new sequence.
                        state_nx = RESET_PLL;
                        cnt_nx   = '0;
                        retry_nx = '0;
                    end
                end
                FAULT: begin
                    state_nx = FAULT;
                end
                default: begin
                    state_nx = RESET_PLL;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Registered outputs decoded from the next state so they move with the state.
    always_ff @(posedge in_clk_27mhz or negedge in_rst_n) begin
        if (!in_rst_n) begin
            bus.out_pll_reset <= 1'b1;
            bus.out_sys_rst_n <= 1'b0;
            bus.out_ready     <= 1'b0;
            bus.out_fault     <= 1'b0;
        end else begin
            bus.out_pll_reset <= (state_nx == RESET_PLL) || (state_nx == FAULT);
            bus.out_sys_rst_n <= (state_nx == RUN);
            bus.out_ready     <= (state_nx == RUN);
            bus.out_fault     <= (state_nx == FAULT);
        end
    end

    assign bus.out_state       = state;
    assign bus.out_retry_count = retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TMO = 32;
    localparam int P_MAX = 2;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STB),
        .LOCK_TIMEOUT_CYCLES(P_TMO),
        .MAX_RETRIES        (P_MAX)
    ) dut (
        .in_clk_27mhz(clk),
        .in_rst_n    (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic lock;
        logic restart;
        int   cycles;
        int   st;
        int   pll;
        int   sys;
        int   rdy;
        int   flt;
        int   ret;
    } step_t;

    step_t steps[$];

    task automatic add(input logic lock, input logic restart, input int cycles, input int st,
                       input int pll, input int sys, input int rdy, input int flt, input int ret);
        step_t s;
        s.lock = lock; s.restart = restart; s.cycles = cycles; s.st = st;
        s.pll = pll; s.sys = sys; s.rdy = rdy; s.flt = flt; s.ret = ret;
        steps.push_back(s);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int st, input int pll, input int sys,
                            input int rdy, input int flt, input int ret);
        chk($sformatf("%s.state", name), 32'(bus.out_state), st);
        chk($sformatf("%s.pll_reset", name), 32'(bus.out_pll_reset), pll);
        chk($sformatf("%s.sys_rst_n", name), 32'(bus.out_sys_rst_n), sys);
        chk($sformatf("%s.ready", name), 32'(bus.out_ready), rdy);
        chk($sformatf("%s.fault", name), 32'(bus.out_fault), flt);
        chk($sformatf("%s.retry", name), 32'(bus.out_retry_count), ret);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: phase plus cycles-remaining countdown, lock seen two edges late.
    int m_ph, m_rem, m_ret;
    logic m_h1, m_ls;

    task automatic model_reset();
        m_ph = 0; m_rem = P_RST; m_ret = 0; m_h1 = 1'b0; m_ls = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic l, input logic rs);
        if (!r) begin
            model_reset();
        end else begin
            if (rs) begin
                m_ph = 0; m_rem = P_RST; m_ret = 0;
            end else if (m_ph == 0) begin
                if (m_rem == 1) begin m_ph = 1; m_rem = P_TMO; end
                else m_rem--;
            end else if (m_ph == 1) begin
                if (m_ls) begin m_ph = 2; m_rem = P_STB; end
                else if (m_rem == 1) begin
                    if (m_ret < P_MAX) begin m_ret++; m_ph = 0; m_rem = P_RST; end
                    else m_ph = 4;
                end else m_rem--;
            end else if (m_ph == 2) begin
                if (!m_ls) begin m_ph = 1; m_rem = P_TMO; end
                else if (m_rem == 1) m_ph = 3;
                else m_rem--;
            end else if (m_ph == 3) begin
                if (!m_ls) begin m_ph = 0; m_rem = P_RST; m_ret = 0; end
            end
            m_ls = m_h1;
            m_h1 = l;
        end
    endtask

    initial begin
        logic lvl;
        int   run_left;
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        bus.in_pll_lock = 1'b0;
        bus.in_restart  = 1'b0;

        // Reset values while held in reset.
        run(3);
        chk_outs("reset", 0, 1, 0, 0, 0, 0);

        // Bring-up, lock loss in RUN, timeouts into FAULT, restart and re-release.
        add(0,0, 3, 0,1,0,0,0,0);  add(0,0, 1, 1,0,0,0,0,0);  add(0,0, 6, 1,0,0,0,0,0);
        add(1,0, 2, 1,0,0,0,0,0);  add(1,0, 1, 2,0,0,0,0,0);  add(1,0, 7, 2,0,0,0,0,0);
        add(1,0, 1, 3,0,1,1,0,0);  add(0,0, 2, 3,0,1,1,0,0);  add(0,0, 1, 0,1,0,0,0,0);
        add(0,0, 3, 0,1,0,0,0,0);  add(0,0, 1, 1,0,0,0,0,0);  add(0,0,31, 1,0,0,0,0,0);
        add(0,0, 1, 0,1,0,0,0,1);  add(0,0, 3, 0,1,0,0,0,1);  add(0,0, 1, 1,0,0,0,0,1);
        add(0,0,31, 1,0,0,0,0,1);  add(0,0, 1, 0,1,0,0,0,2);  add(0,0, 3, 0,1,0,0,0,2);
        add(0,0, 1, 1,0,0,0,0,2);  add(0,0,31, 1,0,0,0,0,2);  add(0,0, 1, 4,1,0,0,1,2);
        add(0,0,20, 4,1,0,0,1,2);  add(1,1, 1, 0,1,0,0,0,0);  add(1,0, 3, 0,1,0,0,0,0);
        add(1,0, 1, 1,0,0,0,0,0);  add(1,0, 1, 2,0,0,0,0,0);  add(1,0, 7, 2,0,0,0,0,0);
        add(1,0, 1, 3,0,1,1,0,0);

        rst_n = 1'b1;
        foreach (steps[i]) begin
            bus.in_pll_lock = steps[i].lock;
            bus.in_restart  = steps[i].restart;
            run(steps[i].cycles);
            chk_outs($sformatf("step%0d", i), steps[i].st, steps[i].pll, steps[i].sys,
                     steps[i].rdy, steps[i].flt, steps[i].ret);
        end

        // Lock glitch in STABLE: back to WAIT_LOCK, no retry, release 11 edges after final rise.
        bus.in_pll_lock = 1'b0; bus.in_restart = 1'b1;
        run(1);
        bus.in_restart = 1'b0;
        run(4);
        chk_outs("glitch.wait", 1, 0, 0, 0, 0, 0);
        bus.in_pll_lock = 1'b1;
        run(5);
        chk_outs("glitch.stable", 2, 0, 0, 0, 0, 0);
        bus.in_pll_lock = 1'b0;
        run(1);
        bus.in_pll_lock = 1'b1;
        run(2);
        chk_outs("glitch.back_wait", 1, 0, 0, 0, 0, 0);
        run(1);
        chk_outs("glitch.restable", 2, 0, 0, 0, 0, 0);
        run(7);
        chk_outs("glitch.pre_release", 2, 0, 0, 0, 0, 0);
        run(1);
        chk_outs("glitch.release", 3, 0, 1, 1, 0, 0);

        // Async reset in the middle of STABLE takes effect without a clock edge.
        bus.in_restart = 1'b1;
        run(1);
        bus.in_restart = 1'b0;
        run(7);
        chk_outs("areset.pre", 2, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk_outs("areset.now", 0, 1, 0, 0, 0, 0);
        bus.in_pll_lock = 1'b0;
        run(1);
        chk_outs("areset.held", 0, 1, 0, 0, 0, 0);

        // Lock arriving on the timeout cycle wins: STABLE, not a retry.
        rst_n = 1'b1;
        run(4);
        chk_outs("tmo_edge.wait", 1, 0, 0, 0, 0, 0);
        run(29);
        bus.in_pll_lock = 1'b1;
        run(2);
        chk_outs("tmo_edge.last", 1, 0, 0, 0, 0, 0);
        run(1);
        chk_outs("tmo_edge.stable", 2, 0, 0, 0, 0, 0);

        // Randomized lock/restart/reset traffic against the reference model.
        rst_n = 1'b0;
        bus.in_restart = 1'b0;
        run(1);
        model_reset();
        run_left = 0;
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lvl = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 150 : 40);
            end
            run_left--;
            bus.in_pll_lock = lvl;
            bus.in_restart  = ($urandom_range(0, 199) == 0);
            rst_n           = ($urandom_range(0, 799) != 0);
            model_step(rst_n, lvl, bus.in_restart);
            run(1);
            chk($sformatf("rand%0d.state", i), 32'(bus.out_state), m_ph);
            chk($sformatf("rand%0d.outs", i),
                32'({bus.out_pll_reset, bus.out_sys_rst_n, bus.out_ready, bus.out_fault, bus.out_retry_count}),
                32'({(m_ph == 0 || m_ph == 4), (m_ph == 3), (m_ph == 3), (m_ph == 4), 4'(m_ret)}));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
